// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Issues one data-memory request per load/store on a req/addr_ok + data_ok
// handshake. A four-state FSM tracks the transaction: IDLE, WAIT, DONE and
// DRAIN. The stage extracts load data, then hands the result to WB.
// Optional feature: define MEM_FWD_LOAD_EN to forward completed load data
// on the front_* bypass port. Without it, only non-load results are forwarded.
module mem_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         WB_allowin,
    input  logic [144:0] EX_to_MEM_zip,
    input  logic [81:0]  EX_except_zip,
    input  logic         flush,
    output logic         data_sram_req,
    output logic         data_sram_wr,
    output logic [1:0]   data_sram_size,
    output logic [3:0]   data_sram_wstrb,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    input  logic         data_sram_addr_ok,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    output logic         MEM_allowin,
    output logic         front_valid,
    output logic [4:0]   front_addr,
    output logic [31:0]  front_data,
    output logic [102:0] MEM_to_WB_reg,
    output logic [81:0]  MEM_except_reg
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        ld_b, ld_bu, ld_h, ld_hu, ld_w;
        logic        st_b, st_h, st_w;
        logic        mem_we;
        logic        res_from_mem;
        logic        gr_we;
        logic [31:0] rkd_value;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
    } ex_bundle_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    ex_bundle_t  ex;
    state_t      state, state_nxt;
    logic        mem_op;
    logic        req_raw;
    logic        ready_go;
    logic        stall;
    logic [31:0] rdata_buf;
    logic [1:0]  size_raw;
    logic [3:0]  wstrb_raw;
    logic [31:0] wdata_raw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ex     = EX_to_MEM_zip;
    assign mem_op = ex.valid & (ex.mem_we | ex.res_from_mem);

    // State register; reset wins over every handshake and abandons any response
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic for the memory transaction
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            S_IDLE:  if (data_sram_req && data_sram_addr_ok) state_nxt = S_WAIT;
            S_WAIT: begin
                if (data_sram_data_ok) state_nxt = flush ? S_IDLE : S_DONE;
                else if (flush)        state_nxt = S_DRAIN;
            end
            S_DRAIN: if (data_sram_data_ok) state_nxt = S_IDLE;
            S_DONE:  if (WB_allowin || flush) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: request strobe, ready_go and the stall that blocks upstream
    always_comb begin
        req_raw  = 1'b0;
        ready_go = 1'b0;
        stall    = 1'b0;
        case (state)
            S_IDLE: begin
                req_raw  = mem_op & ~flush;
                ready_go = ex.valid & ~mem_op;
            end
            S_DONE:  ready_go = 1'b1;
            default: stall    = 1'b1;
        endcase
    end

    assign MEM_allowin = ~stall & (~ex.valid | (ready_go & WB_allowin));

    // Request field encoding: access size, byte strobes and lane-replicated data
    always_comb begin
        size_raw  = 2'd2;
        wstrb_raw = 4'b0000;
        wdata_raw = ex.rkd_value;
        if (ex.ld_b || ex.ld_bu || ex.st_b)      size_raw = 2'd0;
        else if (ex.ld_h || ex.ld_hu || ex.st_h) size_raw = 2'd1;
        if (ex.st_b) begin
            wstrb_raw = 4'b0001 << ex.result[1:0];
            wdata_raw = {4{ex.rkd_value[7:0]}};
        end else if (ex.st_h) begin
            wstrb_raw = ex.result[1] ? 4'b1100 : 4'b0011;
            wdata_raw = {2{ex.rkd_value[15:0]}};
        end else if (ex.st_w) begin
            wstrb_raw = 4'b1111;
        end
    end

    // Request channel is held at zero while reset is asserted
    assign data_sram_req   = req_raw & ~rst;
    assign data_sram_wr    = ex.mem_we & ~rst;
    assign data_sram_size  = rst ? 2'd0   : size_raw;
    assign data_sram_wstrb = rst ? 4'd0   : wstrb_raw;
    assign data_sram_addr  = rst ? 32'd0  : ex.result;
    assign data_sram_wdata = rst ? 32'd0  : wdata_raw;

    // Response buffer: captures rdata only for a transaction that was not flushed
    always_ff @(posedge clk) begin
        if (rst)
            rdata_buf <= 32'd0;
        else if (state == S_WAIT && data_sram_data_ok && !flush)
            rdata_buf <= data_sram_rdata;
    end

    // Load extraction: pick the addressed byte/half and extend it
    always_comb begin
        ld_byte   = rdata_buf[{ex.result[1:0], 3'b000} +: 8];
        ld_half   = ex.result[1] ? rdata_buf[31:16] : rdata_buf[15:0];
        load_data = 32'd0;
        if (ex.ld_b)       load_data = {{24{ld_byte[7]}}, ld_byte};
        else if (ex.ld_bu) load_data = {24'd0, ld_byte};
        else if (ex.ld_h)  load_data = {{16{ld_half[15]}}, ld_half};
        else if (ex.ld_hu) load_data = {16'd0, ld_half};
        else if (ex.ld_w)  load_data = rdata_buf;
    end

    assign final_result = ex.res_from_mem ? load_data : ex.result;

    // MEM->WB pipeline registers: load on handoff, bubble when WB takes nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            MEM_to_WB_reg  <= '0;
            MEM_except_reg <= '0;
        end else if (WB_allowin) begin
            if (ready_go && !flush) begin
                MEM_to_WB_reg  <= {ex.valid, ex.pc, ex.ir, ex.gr_we, ex.rf_waddr, final_result};
                MEM_except_reg <= EX_except_zip;
            end else begin
                MEM_to_WB_reg  <= '0;
                MEM_except_reg <= '0;
            end
        end
    end

    assign front_addr = ex.rf_waddr;
    assign front_data = final_result;
`ifdef MEM_FWD_LOAD_EN
    assign front_valid = ex.valid & ex.gr_we & (~ex.res_from_mem | (state == S_DONE));
`else
    assign front_valid = ex.valid & ex.gr_we & ~ex.res_from_mem;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Expected values are hand-computed constants and small packing helpers.
module tb_mem_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        ld_b, ld_bu, ld_h, ld_hu, ld_w;
        logic        st_b, st_h, st_w;
        logic        mem_we;
        logic        res_from_mem;
        logic        gr_we;
        logic [31:0] rkd_value;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
    } ex_t;

`ifdef MEM_FWD_LOAD_EN
    localparam logic FWD_EXP = 1'b1;
`else
    localparam logic FWD_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         WB_allowin;
    ex_t          ex;
    logic [144:0] EX_to_MEM_zip;
    logic [81:0]  EX_except_zip;
    logic         flush;
    logic         data_sram_req, data_sram_wr;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    logic         data_sram_addr_ok, data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         MEM_allowin, front_valid;
    logic [4:0]   front_addr;
    logic [31:0]  front_data;
    logic [102:0] MEM_to_WB_reg;
    logic [81:0]  MEM_except_reg;

    int n_tests = 0;
    int n_fail  = 0;

    // Load vectors: kind (0 ld_b,1 ld_bu,2 ld_h,3 ld_hu,4 ld_w), address, memory word, expected result, size
    int          ld_kind [5] = '{0, 1, 2, 3, 4};
    logic [31:0] ld_addr [5] = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002, 32'h1000_0000, 32'h1000_0001};
    logic [31:0] ld_rdata[5] = '{32'h80FF_FF00, 32'h80FF_FF00, 32'h8001_1234, 32'h8001_F234, 32'hCAFE_BABE};
    logic [31:0] ld_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_F234, 32'hCAFE_BABE};
    int          ld_size [5] = '{0, 0, 1, 1, 2};

    // Store vectors: kind (5 st_b,6 st_h,7 st_w), address, rkd, strobe, data, size, addr_ok latency
    int          st_kind [3] = '{6, 5, 7};
    logic [31:0] st_addr [3] = '{32'h2000_0002, 32'h2000_0001, 32'h2000_0008};
    logic [31:0] st_rkd  [3] = '{32'h0000_ABCD, 32'h1234_565A, 32'h1122_3344};
    logic [3:0]  st_strb [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] st_data [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h1122_3344};
    int          st_size [3] = '{1, 0, 2};
    int          st_lat  [3] = '{0, 0, 3};

    assign EX_to_MEM_zip = ex;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .WB_allowin       (WB_allowin),
        .EX_to_MEM_zip    (EX_to_MEM_zip),
        .EX_except_zip    (EX_except_zip),
        .flush            (flush),
        .data_sram_req    (data_sram_req),
        .data_sram_wr     (data_sram_wr),
        .data_sram_size   (data_sram_size),
        .data_sram_wstrb  (data_sram_wstrb),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata),
        .MEM_allowin      (MEM_allowin),
        .front_valid      (front_valid),
        .front_addr       (front_addr),
        .front_data       (front_data),
        .MEM_to_WB_reg    (MEM_to_WB_reg),
        .MEM_except_reg   (MEM_except_reg)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_t mk_alu(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] res);
        ex_t e = '0;
        e.valid    = 1'b1;
        e.pc       = pc;
        e.ir       = ~pc;
        e.gr_we    = 1'b1;
        e.rf_waddr = rd;
        e.result   = res;
        return e;
    endfunction

    function automatic ex_t mk_mem(input int kind, input logic [31:0] pc, input logic [4:0] rd,
                                   input logic [31:0] addr, input logic [31:0] rkd);
        ex_t e = '0;
        e.valid     = 1'b1;
        e.pc        = pc;
        e.ir        = pc ^ 32'h0F0F_0F0F;
        e.rf_waddr  = rd;
        e.result    = addr;
        e.rkd_value = rkd;
        case (kind)
            0: e.ld_b  = 1'b1;
            1: e.ld_bu = 1'b1;
            2: e.ld_h  = 1'b1;
            3: e.ld_hu = 1'b1;
            4: e.ld_w  = 1'b1;
            5: e.st_b  = 1'b1;
            6: e.st_h  = 1'b1;
            default: e.st_w = 1'b1;
        endcase
        if (kind <= 4) begin
            e.res_from_mem = 1'b1;
            e.gr_we        = 1'b1;
        end else begin
            e.mem_we = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [102:0] wb_of(input ex_t e, input logic [31:0] fr);
        return {1'b1, e.pc, e.ir, e.gr_we, e.rf_waddr, fr};
    endfunction

    // Drives one full transaction from IDLE to DONE; counts req cycles and handshakes.
    task automatic run_txn(input int aok_lat, input int dok_lat, input logic [31:0] rdata,
                           output int req_cycles, output int hs);
        req_cycles = 0;
        hs         = 0;
        for (int i = 0; i <= aok_lat; i++) begin
            data_sram_addr_ok = (i == aok_lat);
            #1;
            if (data_sram_req) req_cycles++;
            if (data_sram_req && data_sram_addr_ok) hs++;
            check("allowin_during_req", 128'(MEM_allowin), 128'(0));
            step();
        end
        data_sram_addr_ok = 1'b0;
        for (int i = 0; i <= dok_lat; i++) begin
            data_sram_data_ok = (i == dok_lat);
            data_sram_rdata   = (i == dok_lat) ? rdata : 32'hDEAD_BEEF;
            #1;
            if (data_sram_req) req_cycles++;
            step();
        end
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_BEEF;
    endtask

    initial begin
        ex_t         e;
        ex_t         alu;
        int          rc;
        int          hs;
        logic [81:0] exc;

        // Reset with a valid store presented: request channel must stay quiet
        rst               = 1'b1;
        flush             = 1'b0;
        WB_allowin        = 1'b1;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        EX_except_zip     = 82'h1_2345;
        ex = mk_mem(7, 32'h1C00_0000, 5'd0, 32'h2000_0000, 32'h55);
        #1;
        check("rst_req",   128'(data_sram_req),   128'(0));
        check("rst_wr",    128'(data_sram_wr),    128'(0));
        check("rst_wstrb", 128'(data_sram_wstrb), 128'(0));
        check("rst_size",  128'(data_sram_size),  128'(0));
        check("rst_addr",  128'(data_sram_addr),  128'(0));
        check("rst_wdata", 128'(data_sram_wdata), 128'(0));
        step();
        step();
        check("rst_wb",    128'(MEM_to_WB_reg),  128'(0));
        check("rst_exc",   128'(MEM_except_reg), 128'(0));
        check("rst_state", 128'(dut.state),      128'(0));
        rst = 1'b0;

        // ALU op: handed to WB next edge with no memory request
        exc = 82'h2_0000_0000_0000_00AB_CDEF;
        ex  = mk_alu(32'h1C00_0010, 5'd5, 32'h1234);
        EX_except_zip = exc;
        #1;
        check("alu_req",        128'(data_sram_req), 128'(0));
        check("alu_allowin",    128'(MEM_allowin),   128'(1));
        check("alu_front_vld",  128'(front_valid),   128'(1));
        check("alu_front_addr", 128'(front_addr),    128'(5));
        check("alu_front_data", 128'(front_data),    128'(32'h1234));
        step();
        check("alu_wb",  128'(MEM_to_WB_reg),  128'({1'b1, 32'h1C00_0010, ~32'h1C00_0010, 1'b1, 5'd5, 32'h1234}));
        check("alu_exc", 128'(MEM_except_reg), 128'(exc));
        ex = '0;
        EX_except_zip = '0;
        step();
        check("bubble_wb", 128'(MEM_to_WB_reg), 128'(0));

        // Loads: extraction and extension at various byte offsets
        for (int i = 0; i < 5; i++) begin
            e  = mk_mem(ld_kind[i], 32'h1C00_0100 + 32'(i * 4), 5'(10 + i), ld_addr[i], 32'd0);
            ex = e;
            #1;
            check("ld_req",     128'(data_sram_req),   128'(1));
            check("ld_wr",      128'(data_sram_wr),    128'(0));
            check("ld_size",    128'(data_sram_size),  128'(ld_size[i]));
            check("ld_wstrb",   128'(data_sram_wstrb), 128'(0));
            check("ld_addr",    128'(data_sram_addr),  128'(ld_addr[i]));
            check("ld_fwd_idle",128'(front_valid),     128'(0));
            run_txn(0, 0, ld_rdata[i], rc, hs);
            check("ld_req_cycles", 128'(rc), 128'(1));
            check("ld_handshakes", 128'(hs), 128'(1));
            #1;
            check("ld_front_data", 128'(front_data),  128'(ld_exp[i]));
            check("ld_fwd_done",   128'(front_valid), 128'(FWD_EXP));
            check("ld_allowin",    128'(MEM_allowin), 128'(1));
            step();
            check("ld_wb", 128'(MEM_to_WB_reg), 128'(wb_of(e, ld_exp[i])));
            ex = '0;
        end

        // Stores: strobes, lane replication, and a delayed addr_ok on the word store
        for (int i = 0; i < 3; i++) begin
            e  = mk_mem(st_kind[i], 32'h1C00_0200 + 32'(i * 4), 5'd0, st_addr[i], st_rkd[i]);
            ex = e;
            #1;
            check("st_wr",    128'(data_sram_wr),    128'(1));
            check("st_size",  128'(data_sram_size),  128'(st_size[i]));
            check("st_wstrb", 128'(data_sram_wstrb), 128'(st_strb[i]));
            check("st_wdata", 128'(data_sram_wdata), 128'(st_data[i]));
            check("st_addr",  128'(data_sram_addr),  128'(st_addr[i]));
            run_txn(st_lat[i], 0, 32'h0, rc, hs);
            check("st_req_cycles", 128'(rc), 128'(st_lat[i] + 1));
            check("st_handshakes", 128'(hs), 128'(1));
            #1;
            check("st_fwd", 128'(front_valid), 128'(0));
            step();
            check("st_wb", 128'(MEM_to_WB_reg), 128'(wb_of(e, st_addr[i])));
            ex = '0;
        end

        // Flush in WAIT, response two cycles later: drain, bubble, no reissue
        ex = mk_mem(4, 32'h1C00_0300, 5'd7, 32'h3000_0000, 32'd0);
        data_sram_addr_ok = 1'b1;
        #1;
        check("fl_req", 128'(data_sram_req), 128'(1));
        step();
        data_sram_addr_ok = 1'b0;
        flush = 1'b1;
        #1;
        check("fl_wait_req",     128'(data_sram_req), 128'(0));
        check("fl_wait_allowin", 128'(MEM_allowin),   128'(0));
        step();
        flush = 1'b0;
        #1;
        check("fl_drain_state", 128'(dut.state),     128'(3));
        check("fl_drain_req",   128'(data_sram_req), 128'(0));
        check("fl_drain_wb",    128'(MEM_to_WB_reg), 128'(0));
        step();
        ex = '0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h7777_7777;
        #1;
        check("fl_drain_allowin", 128'(MEM_allowin), 128'(0));
        step();
        data_sram_data_ok = 1'b0;
        #1;
        check("fl_idle_state",   128'(dut.state),     128'(0));
        check("fl_idle_allowin", 128'(MEM_allowin),   128'(1));
        check("fl_idle_wb",      128'(MEM_to_WB_reg), 128'(0));

        // WB stalled in DONE for five cycles: register holds, then hands off
        alu = mk_alu(32'h1C00_0400, 5'd3, 32'h0000_A5A5);
        ex  = alu;
        step();
        check("stall_pre_wb", 128'(MEM_to_WB_reg), 128'(wb_of(alu, 32'h0000_A5A5)));
        e  = mk_mem(3, 32'h1C00_0404, 5'd9, 32'h1000_0002, 32'd0);
        ex = e;
        WB_allowin = 1'b0;
        run_txn(0, 0, 32'h8001_1234, rc, hs);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_allowin", 128'(MEM_allowin),   128'(0));
            check("stall_wb",      128'(MEM_to_WB_reg), 128'(wb_of(alu, 32'h0000_A5A5)));
            step();
        end
        WB_allowin = 1'b1;
        #1;
        check("stall_release_allowin", 128'(MEM_allowin), 128'(1));
        step();
        check("stall_release_wb", 128'(MEM_to_WB_reg), 128'(wb_of(e, 32'h0000_8001)));
        ex = '0;

        // Reset in WAIT: outstanding response abandoned, everything cleared
        alu = mk_alu(32'h1C00_0500, 5'd4, 32'h99);
        ex  = alu;
        EX_except_zip = exc;
        step();
        ex = mk_mem(4, 32'h1C00_0504, 5'd6, 32'h1000_0004, 32'd0);
        WB_allowin = 1'b0;
        data_sram_addr_ok = 1'b1;
        step();
        data_sram_addr_ok = 1'b0;
        #1;
        check("rw_state_wait", 128'(dut.state), 128'(1));
        rst = 1'b1;
        step();
        check("rw_state", 128'(dut.state),       128'(0));
        check("rw_req",   128'(data_sram_req),   128'(0));
        check("rw_addr",  128'(data_sram_addr),  128'(0));
        check("rw_wstrb", 128'(data_sram_wstrb), 128'(0));
        check("rw_wb",    128'(MEM_to_WB_reg),   128'(0));
        check("rw_exc",   128'(MEM_except_reg),  128'(0));
        rst = 1'b0;
        ex  = '0;
        EX_except_zip = '0;
        WB_allowin = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        step();
        data_sram_data_ok = 1'b0;
        #1;
        check("rw_stale_ok_state", 128'(dut.state), 128'(0));
        alu = mk_alu(32'h1C00_0600, 5'd8, 32'h4321);
        ex  = alu;
        step();
        check("rw_after_wb", 128'(MEM_to_WB_reg), 128'(wb_of(alu, 32'h4321)));
        ex = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
